// File: rtl/maxnet_pkg.sv
// Shared definitions for the maxnet loader block.
//   - default widths/limits for XLEN, NUM_IN and MAX_ITER
//   - FSM state encoding used by maxnet_loader
//   - RUN-cycle counter width and the limit-compare helper
package maxnet_pkg;

   localparam int XLEN_DEF     = 32;
   localparam int NUM_IN_DEF   = 4;
   localparam int MAX_ITER_DEF = 255;

   localparam int CNT_W = 8;
   localparam int IDX_W = 2;

   typedef logic [2:0] state_t;

   localparam logic [2:0] ST_LOAD   = 3'd0;
   localparam logic [2:0] ST_FLUSH  = 3'd1;
   localparam logic [2:0] ST_START  = 3'd2;
   localparam logic [2:0] ST_RUN    = 3'd3;
   localparam logic [2:0] ST_RESULT = 3'd4;

   // True on the last RUN cycle allowed before the iteration limit fires.
   function automatic logic at_iter_limit(input logic [CNT_W-1:0] cnt, input int lim);
      return (cnt == CNT_W'(lim - 1));
   endfunction

endpackage

// File: rtl/maxnet_loader_if.sv
// Bundle of every handshake/bus signal of the maxnet loader.
//   input stream : inValid, inData -> loader ; inReady <- loader
//   memory write : wrEn, wrAddr, wrData      <- loader
//   datapath     : start <- loader ; done, maxNumber -> loader
//   result       : resValid, resData, timeout <- loader ; resReady -> loader
//   status       : busy <- loader
// master = the loader itself, slave = the surrounding environment.
interface maxnet_loader_if import maxnet_pkg::*; #(
   parameter int XLEN = XLEN_DEF
);
   logic             inValid;
   logic [XLEN-1:0]  inData;
   logic             inReady;
   logic             wrEn;
   logic [IDX_W-1:0] wrAddr;
   logic [XLEN-1:0]  wrData;
   logic             start;
   logic             done;
   logic [XLEN-1:0]  maxNumber;
   logic             resValid;
   logic [XLEN-1:0]  resData;
   logic             resReady;
   logic             timeout;
   logic             busy;

   modport master (
      input  inValid, inData, done, maxNumber, resReady,
      output inReady, wrEn, wrAddr, wrData, start, resValid, resData, timeout, busy
   );

   modport slave (
      output inValid, inData, done, maxNumber, resReady,
      input  inReady, wrEn, wrAddr, wrData, start, resValid, resData, timeout, busy
   );
endinterface

// File: rtl/maxnet_loader_iter_counter.sv
// RUN-cycle counter for the maxnet loader.
//   clk, rst  : clock, asynchronous active-low reset
//   clear     : zero the count (asserted the cycle before RUN is entered)
//   en        : count one RUN cycle
//   at_limit  : current RUN cycle is number MAX_ITER
module iter_counter import maxnet_pkg::*; #(
   parameter int MAX_ITER = MAX_ITER_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic at_limit
);
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign at_limit = at_iter_limit(cnt, MAX_ITER);
endmodule

// File: rtl/maxnet_loader.sv
// Loads a set of NUM_IN words into the maxnet data memory, launches the
// datapath, then waits for done or the iteration limit and presents the result.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : maxnet_loader_if.master (input stream, memory write port,
//              start/done datapath control, result handshake, busy)
module maxnet_loader import maxnet_pkg::*; #(
   parameter int XLEN     = XLEN_DEF,
   parameter int NUM_IN   = NUM_IN_DEF,
   parameter int MAX_ITER = MAX_ITER_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   maxnet_loader_if.master      bus
);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic             xfer;
   logic             at_limit;
   logic             wr_en;
   logic [IDX_W-1:0] wr_addr;
   logic [XLEN-1:0]  wr_data;
   logic [XLEN-1:0]  res_data;
   logic             tmo;

   // Words are only accepted in LOAD; anything offered later simply stalls.
   assign xfer = bus.inValid && (state == ST_LOAD);

   assign bus.inReady  = (state == ST_LOAD);
   assign bus.start    = (state == ST_START);
   assign bus.resValid = (state == ST_RESULT);
   assign bus.busy     = !((state == ST_LOAD) && (idx == '0));
   assign bus.wrEn     = wr_en;
   assign bus.wrAddr   = wr_addr;
   assign bus.wrData   = wr_data;
   assign bus.resData  = res_data;
   assign bus.timeout  = tmo;

   // Count is zeroed while in START so the first RUN cycle sees 0.
   iter_counter #(.MAX_ITER(MAX_ITER)) u_iter (
      .clk      (clk),
      .rst      (rst),
      .clear    (state == ST_START),
      .en       (state == ST_RUN),
      .at_limit (at_limit)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_LOAD;
         idx      <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         res_data <= '0;
         tmo      <= 1'b0;
      end else begin
         // Memory write trails the accepted word by one cycle.
         wr_en <= xfer;
         if (xfer) begin
            wr_addr <= idx;
            wr_data <= bus.inData;
         end

         case (state)
            ST_LOAD: begin
               if (xfer) begin
                  if (idx == LAST_IDX) begin
                     idx   <= '0;
                     state <= ST_FLUSH;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            ST_FLUSH: state <= ST_START;
            ST_START: state <= ST_RUN;
            ST_RUN: begin
               // done outranks the iteration limit in the same cycle.
               if (bus.done) begin
                  res_data <= bus.maxNumber;
                  tmo      <= 1'b0;
                  state    <= ST_RESULT;
               end else if (at_limit) begin
                  res_data <= '0;
                  tmo      <= 1'b1;
                  state    <= ST_RESULT;
               end
            end
            ST_RESULT: begin
               if (bus.resReady) begin
                  idx   <= '0;
                  state <= ST_LOAD;
               end
            end
            default: begin
               idx   <= '0;
               state <= ST_LOAD;
            end
         endcase
      end
   end
endmodule

// File: doc/maxnet_loader.md
MAXNET_LOADER -- requirements
Module: maxnet_loader

Interface
REQ-001 SHALL have parameter XLEN, default 32, data word width.
REQ-002 SHALL have parameter NUM_IN, default 4, words per input set; fixed at 4, so wrAddr is 2 bits.
REQ-003 SHALL have parameter MAX_ITER, default 255, RUN-cycle limit before timeout; range 1..255.
REQ-004 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports inValid, input, 1 / inData, input, XLEN / inReady, output, 1: input-word stream handshake.
REQ-007 SHALL have ports wrEn, output, 1 / wrAddr, output, 2 / wrData, output, XLEN: data-memory write port.
REQ-008 SHALL have port start, output, 1, one-cycle pulse that launches the maxnet datapath.
REQ-009 SHALL have ports done, input, 1 / maxNumber, input, XLEN: datapath completion flag and winning value.
REQ-010 SHALL have ports resValid, output, 1 / resData, output, XLEN / resReady, input, 1: result handshake.
REQ-011 SHALL have port timeout, output, 1, result produced by iteration limit, not by done.
REQ-012 SHALL have port busy, output, 1, high unless in LOAD with word count 0.

Function
REQ-013 SHALL implement states LOAD, FLUSH, START, RUN, RESULT.
REQ-014 SHALL drive inReady = 1 only in LOAD (combinational from state); a word transfers when inValid & inReady.
REQ-015 SHALL, one cycle after each transfer, assert wrEn for exactly one cycle with wrAddr = word index (0..3, arrival order) and wrData = transferred word.
REQ-016 SHALL, on transfer of word index 3, go LOAD -> FLUSH; the index-3 write occurs in FLUSH; inReady = 0 from FLUSH onward.
REQ-017 SHALL go FLUSH -> START -> RUN unconditionally; start = 1 only in START, so start follows the last write by one cycle.
REQ-018 SHALL ignore done in every state except RUN.
REQ-019 SHALL count RUN cycles from 0 in an 8-bit counter cleared on entering RUN.
REQ-020 SHALL, in a RUN cycle with done = 1, capture maxNumber into resData, clear timeout, go to RESULT.
REQ-021 SHALL, in a RUN cycle with done = 0 and counter = MAX_ITER-1, set resData = 0 and timeout = 1, go to RESULT; done in that same cycle wins per REQ-020.
REQ-022 SHALL hold resValid = 1 with resData and timeout stable for all of RESULT until resReady = 1.
REQ-023 SHALL, on resValid & resReady, go to LOAD with word index 0; resValid drops and inReady rises next cycle.
REQ-024 SHALL not accept inValid in RESULT, including the resReady handshake cycle.
REQ-025 SHALL keep inData words beyond index 3 stalled (inReady = 0), never dropped.

Reset
REQ-026 SHALL, on rst = 0, immediately set state LOAD, word index 0, RUN counter 0, resData 0.
REQ-027 SHALL, on rst = 0, immediately set wrEn, wrAddr, wrData, start, resValid, timeout and busy to 0, and inReady to 1.
REQ-028 SHALL, on reset mid-operation, discard any pending write and unissued start; the next set begins at index 0.

Structure
REQ-029 SHALL take XLEN, NUM_IN, MAX_ITER defaults and the state encoding from shared package maxnet_pkg.
REQ-030 SHALL implement the RUN counter with its clear/limit compare as sub-module iter_counter; the FSM, index counter and registers live in maxnet_loader.

Verification
REQ-031 SHALL cover: stream 5,9,2,7 back-to-back -> writes addr 0..3 data 5,9,2,7 one cycle after each transfer; start 1 cycle after addr-3 write; done with maxNumber=9 after 3 RUN cycles -> resValid, resData=9, timeout=0.
REQ-032 SHALL cover: inValid gaps and 5th word offered during FLUSH/RUN -> inReady=0, 5th word held until LOAD resumes as index 0 of the next set.
REQ-033 SHALL cover: MAX_ITER=4, done never asserted -> RESULT after 4 RUN cycles, resData=0, timeout=1; done on the 4th cycle instead -> timeout=0.
REQ-034 SHALL cover: done=1 during LOAD and START -> ignored; resReady held low 10 cycles -> resValid and resData stable throughout.
REQ-035 SHALL cover: rst=0 asynchronously in RUN after 2 writes of the next set -> outputs per REQ-027 immediately, no start; new set of 1,1,1,3 completes with resData=3.
